// File: rtl/semimips_pkg.sv
// semimips_pkg: shared constants and types for the stall controller slice.
//   REG_ADDR_W  architectural register number width
//   state_e     stall FSM encoding (RUN / MDU_WAIT)
//   ctl_t       bundle of pipeline enable/flush controls
//   src_hit()   "nonzero register that matches one of the Decode sources"
package semimips_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MDU_WAIT = 2'b01
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic en_d;
    logic en_e;
    logic flush_e;
    logic flush_m;
  } ctl_t;

  // Free-running pipeline, a load-use/branch bubble, and the MDU freeze.
  localparam ctl_t CTL_RUN   = '{pc_en: 1'b1, en_d: 1'b1, en_e: 1'b1, flush_e: 1'b0, flush_m: 1'b0};
  localparam ctl_t CTL_STALL = '{pc_en: 1'b0, en_d: 1'b0, en_e: 1'b1, flush_e: 1'b1, flush_m: 1'b0};
  localparam ctl_t CTL_WAIT  = '{pc_en: 1'b0, en_d: 1'b0, en_e: 1'b0, flush_e: 1'b0, flush_m: 1'b1};

  // r0 is hardwired to zero, so it never creates a dependency.
  function automatic logic src_hit(input logic [REG_ADDR_W-1:0] r,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic [REG_ADDR_W-1:0] rt);
    return (r != '0) && ((r == rs) || (r == rt));
  endfunction

endpackage

// File: rtl/stall_hazard_cmp.sv
// stall_hazard_cmp: purely combinational hazard detection.
//   RsD/RtD           Decode source registers
//   RtE/MemtoRegE     load in Execute (load-use hazard)
//   RegWriteE/WriteRegE, MemtoRegM/WriteRegM, BranchD  branch-operand hazard
//   lu                load-use stall request
//   br                branch stall request
module stall_hazard_cmp
  import semimips_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic                  MemtoRegE,
  input  logic                  RegWriteE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic                  MemtoRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic                  BranchD,
  output logic                  lu,
  output logic                  br
);

  assign lu = MemtoRegE & src_hit(RtE, RsD, RtD);

  // Branches resolve in Decode, so they must wait for an ALU result still in
  // Execute or a load result still in Memory.
  assign br = BranchD & ((RegWriteE & src_hit(WriteRegE, RsD, RtD)) |
                         (MemtoRegM & src_hit(WriteRegM, RsD, RtD)));

endmodule

// File: rtl/stall_controller.sv
// stall_controller: pipeline stall/flush control for the 5-stage core.
//   clk, reset          clock, synchronous active-high reset
//   RsD..BranchD        hazard inputs (see stall_hazard_cmp)
//   MduStartE/MduDoneE  multi-cycle multiply/divide handshake
//   PCEn/EnD/EnE        PC, IF/ID, ID/EX register enables
//   FlushE/FlushM       synchronous clears of ID/EX and EX/MEM
//   StallCount          cycles spent in the current or last MDU wait
//   MduTimeout          sticky: an MDU wait was abandoned at MDU_MAX_CYCLES
module stall_controller
  import semimips_pkg::*;
#(
  parameter int MDU_MAX_CYCLES = 32,
  parameter int CNT_W          = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic                  MemtoRegE,
  input  logic                  RegWriteE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic                  MemtoRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic                  BranchD,
  input  logic                  MduStartE,
  input  logic                  MduDoneE,
  output logic                  PCEn,
  output logic                  EnD,
  output logic                  EnE,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic [CNT_W-1:0]      StallCount,
  output logic                  MduTimeout
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MDU_MAX_CYCLES - 1);

  state_e           state;
  logic             lu, br;
  logic [CNT_W-1:0] cnt_inc;
  ctl_t             ctl;

  stall_hazard_cmp u_cmp (
    .RsD       (RsD),
    .RtD       (RtD),
    .RtE       (RtE),
    .MemtoRegE (MemtoRegE),
    .RegWriteE (RegWriteE),
    .WriteRegE (WriteRegE),
    .MemtoRegM (MemtoRegM),
    .WriteRegM (WriteRegM),
    .BranchD   (BranchD),
    .lu        (lu),
    .br        (br)
  );

  assign cnt_inc = (&StallCount) ? StallCount : StallCount + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      StallCount <= '0;
      MduTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MduStartE) begin
            state      <= MDU_WAIT;
            StallCount <= '0;
          end
        end
        MDU_WAIT: begin
          // Counts every wait cycle, including the one that exits.
          StallCount <= cnt_inc;
          if (MduDoneE) begin
            state <= RUN;                // done beats a coincident timeout
          end else if (StallCount == LAST_CNT) begin
            state      <= RUN;
            MduTimeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Hazard stalls must take effect in the same cycle, so the decode is
  // combinational off the registered state; reset forces a free-running pipe.
  always_comb begin
    ctl = CTL_RUN;
    if (!reset) begin
      if (state == MDU_WAIT)  ctl = CTL_WAIT;
      else if (lu | br)       ctl = CTL_STALL;
    end
  end

  assign PCEn   = ctl.pc_en;
  assign EnD    = ctl.en_d;
  assign EnE    = ctl.en_e;
  assign FlushE = ctl.flush_e;
  assign FlushM = ctl.flush_m;

endmodule

// File: tb/tb_stall_controller.sv
module tb_stall_controller;

  localparam int MAXC = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    RsD, RtD, RtE, WriteRegE, WriteRegM;
  logic          MemtoRegE, RegWriteE, MemtoRegM, BranchD, MduStartE, MduDoneE;
  logic          PCEn, EnD, EnE, FlushE, FlushM, MduTimeout;
  logic [CW-1:0] StallCount;

  int nvec = 0;
  int nerr = 0;

  // Reference model: "are we frozen for the MDU", how many wait cycles so far,
  // and whether any wait was abandoned.
  bit m_wait;
  int m_cnt;
  bit m_tmo;
  bit known = 1'b0;

  always #5 clk = ~clk;

  stall_controller #(.MDU_MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RtE(RtE),
    .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .WriteRegE(WriteRegE),
    .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .BranchD(BranchD),
    .MduStartE(MduStartE), .MduDoneE(MduDoneE),
    .PCEn(PCEn), .EnD(EnD), .EnE(EnE), .FlushE(FlushE), .FlushM(FlushM),
    .StallCount(StallCount), .MduTimeout(MduTimeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit uses(input logic [4:0] r);
    return (r != 0) && (r == RsD || r == RtD);
  endfunction

  // Check combinational outputs for the current inputs and model state.
  task automatic settle();
    bit stall;
    logic [4:0] exp;
    #1;
    stall = (MemtoRegE && uses(RtE)) ||
            (BranchD && ((RegWriteE && uses(WriteRegE)) || (MemtoRegM && uses(WriteRegM))));
    if (reset)       exp = 5'b11100;
    else if (m_wait) exp = 5'b00001;
    else if (stall)  exp = 5'b00110;
    else             exp = 5'b11100;
    chk("ctl{PCEn,EnD,EnE,FlushE,FlushM}", {27'd0, PCEn, EnD, EnE, FlushE, FlushM}, {27'd0, exp});
    if (known) begin
      chk("StallCount", {28'd0, StallCount}, m_cnt);
      chk("MduTimeout", {31'd0, MduTimeout}, {31'd0, m_tmo});
    end
  endtask

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_cnt = 0; m_tmo = 0; known = 1;
    end else if (!m_wait) begin
      if (MduStartE) begin m_wait = 1; m_cnt = 0; end
    end else begin
      int last_cnt;
      last_cnt = m_cnt;
      m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
      if (MduDoneE) m_wait = 0;
      else if (last_cnt == MAXC - 1) begin m_wait = 0; m_tmo = 1; end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; RsD = 0; RtD = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0;
    MemtoRegE = 0; RegWriteE = 0; MemtoRegM = 0; BranchD = 0;
    MduStartE = 0; MduDoneE = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    RsD = 3; RtE = 3; MemtoRegE = 1;   // a hazard must not leak through reset
    settle(); chk("reset_pcen", {31'd0, PCEn}, 32'd1);
    tick();
    settle(); tick();
    idle();
    settle(); chk("after_reset_cnt", {28'd0, StallCount}, 32'd0);
    tick();

    // load-use: RtE matches RsD
    RtE = 3; MemtoRegE = 1; RsD = 3;
    settle();
    chk("lu_pcen", {31'd0, PCEn}, 32'd0);
    chk("lu_flushe", {31'd0, FlushE}, 32'd1);
    tick();
    RtE = 0; RsD = 0;
    settle(); chk("lu_r0_pcen", {31'd0, PCEn}, 32'd1);
    tick();
    idle();

    // branch vs load in Memory
    BranchD = 1; RsD = 5; MemtoRegM = 1; WriteRegM = 5;
    settle(); chk("br_pcen", {31'd0, PCEn}, 32'd0);
    tick();
    WriteRegM = 6;
    settle(); chk("br_miss_pcen", {31'd0, PCEn}, 32'd1);
    tick();
    idle();

    // MDU with done after 4 wait cycles
    MduStartE = 1; settle(); tick(); MduStartE = 0;
    for (int i = 0; i < 4; i++) begin
      MduDoneE = (i == 3);
      settle();
      chk("mdu4_pcen", {31'd0, PCEn}, 32'd0);
      chk("mdu4_flushm", {31'd0, FlushM}, 32'd1);
      tick();
    end
    idle();
    settle();
    chk("mdu4_run_pcen", {31'd0, PCEn}, 32'd1);
    chk("mdu4_cnt", {28'd0, StallCount}, 32'd4);
    tick();

    // timeout after MAXC wait cycles
    MduStartE = 1; settle(); tick(); MduStartE = 0;
    for (int i = 0; i < MAXC; i++) begin
      settle(); chk("tmo_flushm", {31'd0, FlushM}, 32'd1); tick();
    end
    settle();
    chk("tmo_exit_pcen", {31'd0, PCEn}, 32'd1);
    chk("tmo_flag", {31'd0, MduTimeout}, 32'd1);
    chk("tmo_cnt", {28'd0, StallCount}, MAXC);
    tick();
    // flag survives a later, completed wait
    MduStartE = 1; settle(); tick(); MduStartE = 0;
    MduDoneE = 1; settle(); tick(); MduDoneE = 0;
    settle(); chk("tmo_sticky", {31'd0, MduTimeout}, 32'd1); tick();

    // reset in the 2nd wait cycle aborts the wait and clears the flag
    MduStartE = 1; settle(); tick(); MduStartE = 0;
    settle(); tick();
    reset = 1; MduDoneE = 1;
    settle(); chk("rst_wait_pcen", {31'd0, PCEn}, 32'd1);
    tick();
    idle();
    settle();
    chk("rst_wait_cnt", {28'd0, StallCount}, 32'd0);
    chk("rst_wait_tmo", {31'd0, MduTimeout}, 32'd0);
    tick();

    // done coincides with the timeout cycle
    MduStartE = 1; settle(); tick(); MduStartE = 0;
    for (int i = 0; i < MAXC; i++) begin
      MduDoneE = (i == MAXC - 1);
      settle(); tick();
    end
    idle();
    settle();
    chk("done_tmo_pcen", {31'd0, PCEn}, 32'd1);
    chk("done_tmo_flag", {31'd0, MduTimeout}, 32'd0);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      RsD       = 5'($urandom_range(0, 3));
      RtD       = 5'($urandom_range(0, 3));
      RtE       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      MemtoRegE = 1'($urandom_range(0, 1));
      RegWriteE = 1'($urandom_range(0, 1));
      MemtoRegM = 1'($urandom_range(0, 1));
      BranchD   = 1'($urandom_range(0, 1));
      MduStartE = ($urandom_range(0, 5) == 0);
      MduDoneE  = ($urandom_range(0, 11) == 0);
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
